// File: rtl/axi_stream_packet_arbiter_pkg.sv
// Shared types for the packet arbiter and its output stage.
package axi_stream_packet_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/axi_stream_pipe_reg.sv
// One-entry AXI-stream register slice; contents hold while the sink stalls.
module axi_stream_pipe_reg #(
  parameter int EW = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [(8<<EW)-1:0]    s_tdata,
  input  logic [(1<<EW)-1:0]    s_tkeep,
  input  logic                  s_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [(8<<EW)-1:0]    m_tdata,
  output logic [(1<<EW)-1:0]    m_tkeep,
  output logic                  m_tlast
);

  localparam int DW = 8 << EW;
  localparam int KW = 1 << EW;

  logic          full_q, full_d;
  logic [DW-1:0] data_q, data_d;
  logic [KW-1:0] keep_q, keep_d;
  logic          last_q, last_d;
  logic          accept;

  // A new beat may enter when empty or when the current one leaves this cycle.
  always_comb begin
    s_tready = ~full_q | m_tready;
    accept   = s_tvalid & s_tready;
    full_d   = full_q;
    data_d   = data_q;
    keep_d   = keep_q;
    last_d   = last_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = s_tdata;
      keep_d = s_tkeep;
      last_d = s_tlast;
    end else if (m_tready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      keep_q <= keep_d;
      last_q <= last_d;
    end
  end

  assign m_tvalid = full_q;
  assign m_tdata  = data_q;
  assign m_tkeep  = keep_q;
  assign m_tlast  = last_q;

endmodule

// File: rtl/axi_stream_packet_arbiter.sv
// Packet-granular round-robin merge of NI AXI-stream inputs into one registered output.
module axi_stream_packet_arbiter
  import axi_stream_packet_arbiter_pkg::*;
#(
  parameter int EW = 2,
  parameter int NI = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [NI-1:0]            i_tready,
  input  logic [NI-1:0]            i_tvalid,
  input  logic [NI*(8<<EW)-1:0]    i_tdata,
  input  logic [NI*(1<<EW)-1:0]    i_tkeep,
  input  logic [NI-1:0]            i_tlast,
  input  logic                     o_tready,
  output logic                     o_tvalid,
  output logic [(8<<EW)-1:0]       o_tdata,
  output logic [(1<<EW)-1:0]       o_tkeep,
  output logic                     o_tlast,
  output logic [NI-1:0]            o_grant
);

  localparam int DW = 8 << EW;
  localparam int KW = 1 << EW;
  localparam int PW = (NI > 1) ? $clog2(NI) : 1;

  arb_state_e    state_q, state_d;
  logic [NI-1:0] grant_q, grant_d;
  logic [PW-1:0] gidx_q, gidx_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  logic [PW-1:0] pick;
  logic          sel_tvalid;
  logic [DW-1:0] sel_tdata;
  logic [KW-1:0] sel_tkeep;
  logic          sel_tlast;
  logic          pipe_in_valid;
  logic          pipe_in_ready;
  logic          accept;

  // Descending scan so the smallest offset from ptr overwrites larger ones.
  function automatic logic [PW-1:0] rr_pick(input logic [NI-1:0] req,
                                            input logic [PW-1:0] ptr);
    logic [PW-1:0] sel;
    int            idx;
    sel = ptr;
    for (int i = NI - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NI;
      if (req[idx]) sel = PW'(idx);
    end
    return sel;
  endfunction

  always_comb begin
    sel_tvalid    = i_tvalid[gidx_q];
    sel_tdata     = i_tdata[int'(gidx_q)*DW +: DW];
    sel_tkeep     = i_tkeep[int'(gidx_q)*KW +: KW];
    sel_tlast     = i_tlast[gidx_q];
    pipe_in_valid = (state_q == ST_PKT) & sel_tvalid & ~rst;
    accept        = pipe_in_valid & pipe_in_ready;
    i_tready      = '0;
    if (state_q == ST_PKT && !rst) begin
      i_tready = grant_q & {NI{pipe_in_ready}};
    end
  end

  // Grant is held from selection until the owner's tlast beat is accepted.
  always_comb begin
    pick     = rr_pick(i_tvalid, rr_ptr_q);
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|i_tvalid) begin
          gidx_d  = pick;
          grant_d = NI'(1) << pick;
          state_d = ST_PKT;
        end
      end
      ST_PKT: begin
        if (accept && sel_tlast) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = (int'(gidx_q) == NI - 1) ? '0 : gidx_q + PW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign o_grant = grant_q;

  axi_stream_pipe_reg #(
    .EW(EW)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (pipe_in_valid),
    .s_tready (pipe_in_ready),
    .s_tdata  (sel_tdata),
    .s_tkeep  (sel_tkeep),
    .s_tlast  (sel_tlast),
    .m_tvalid (o_tvalid),
    .m_tready (o_tready),
    .m_tdata  (o_tdata),
    .m_tkeep  (o_tkeep),
    .m_tlast  (o_tlast)
  );

endmodule

// File: tb/tb_axi_stream_packet_arbiter.sv
// Directed self-checking bench: a two-input instance driven by simple packet
// sources, plus a four-input instance for round-robin pointer checks.
module tb_axi_stream_packet_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [1:0]   i2_tready, i2_tvalid, i2_tlast;
  logic [63:0]  i2_tdata;
  logic [7:0]   i2_tkeep;
  logic         o2_tready, o2_tvalid, o2_tlast;
  logic [31:0]  o2_tdata;
  logic [3:0]   o2_tkeep;
  logic [1:0]   o2_grant;

  logic [3:0]   i4_tready, i4_tvalid, i4_tlast;
  logic [127:0] i4_tdata;
  logic [15:0]  i4_tkeep;
  logic         o4_tready, o4_tvalid, o4_tlast;
  logic [31:0]  o4_tdata;
  logic [3:0]   o4_tkeep;
  logic [3:0]   o4_grant;

  axi_stream_packet_arbiter #(.EW(2), .NI(2)) dut2 (
    .clk(clk), .rst(rst),
    .i_tready(i2_tready), .i_tvalid(i2_tvalid), .i_tdata(i2_tdata),
    .i_tkeep(i2_tkeep), .i_tlast(i2_tlast),
    .o_tready(o2_tready), .o_tvalid(o2_tvalid), .o_tdata(o2_tdata),
    .o_tkeep(o2_tkeep), .o_tlast(o2_tlast), .o_grant(o2_grant)
  );

  axi_stream_packet_arbiter #(.EW(2), .NI(4)) dut4 (
    .clk(clk), .rst(rst),
    .i_tready(i4_tready), .i_tvalid(i4_tvalid), .i_tdata(i4_tdata),
    .i_tkeep(i4_tkeep), .i_tlast(i4_tlast),
    .o_tready(o4_tready), .o_tvalid(o4_tvalid), .o_tdata(o4_tdata),
    .o_tkeep(o4_tkeep), .o_tlast(o4_tlast), .o_grant(o4_grant)
  );

  // Packet source state for the two-input instance.
  int          src_beat[2];
  int          src_len[2];
  int          src_left[2];
  logic [7:0]  src_base[2];
  bit          src_hold[2];

  logic [31:0] q_data[$];
  logic [3:0]  q_keep[$];
  logic        q_last[$];
  int          q_cyc[$];
  int          cyc;
  bit          last_stall;
  logic [31:0] last_od;

  task automatic drive2();
    for (int k = 0; k < 2; k++) begin
      i2_tvalid[k]         = (src_left[k] > 0) && !src_hold[k];
      i2_tdata[k*32 +: 32] = {24'h0, src_base[k] + 8'(src_beat[k])};
      i2_tkeep[k*4 +: 4]   = (src_beat[k] == src_len[k] - 1) ? 4'h1 : 4'hF;
      i2_tlast[k]          = (src_beat[k] == src_len[k] - 1);
    end
  endtask

  task automatic set_src(input int k, input logic [7:0] base, input int len, input int npkts);
    src_base[k] = base;
    src_len[k]  = len;
    src_left[k] = npkts;
    src_beat[k] = 0;
    src_hold[k] = 1'b0;
  endtask

  // Observe at negedge, commit at posedge, then advance sources that were accepted.
  task automatic cycle2();
    logic [1:0] acc;
    @(negedge clk);
    acc = i2_tvalid & i2_tready;
    if (o2_tvalid && o2_tready) begin
      q_data.push_back(o2_tdata);
      q_keep.push_back(o2_tkeep);
      q_last.push_back(o2_tlast);
      q_cyc.push_back(cyc);
    end
    last_stall = o2_tvalid && !o2_tready;
    last_od    = o2_tdata;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (acc[k]) begin
        if (src_beat[k] == src_len[k] - 1) begin
          src_beat[k] = 0;
          if (src_left[k] > 0) src_left[k]--;
        end else begin
          src_beat[k]++;
        end
      end
    end
    drive2();
    #1;
  endtask

  task automatic tick4();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) set_src(k, 8'h00, 1, 0);
    o2_tready = 1'b1;
    drive2();
    i4_tvalid = '0;
    i4_tlast  = '0;
    i4_tdata  = '0;
    i4_tkeep  = '0;
    o4_tready = 1'b1;
    cycle2();
    cycle2();
    rst = 1'b0;
    q_data.delete();
    q_keep.delete();
    q_last.delete();
    q_cyc.delete();
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    o2_tready = 1'b1;
    set_src(0, 8'hA0, 3, 1);
    set_src(1, 8'hB0, 3, 1);
    drive2();
    i4_tvalid = 4'hF;
    i4_tlast  = 4'hF;
    i4_tdata  = '0;
    i4_tkeep  = '1;
    o4_tready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cycle2();
      checks++;
      if (o2_tvalid !== 1'b0 || o2_grant !== 2'b00 || i2_tready !== 2'b00) begin
        errors++;
        $display("[TB] FAIL reset_hold cycle %0d: got tvalid=%b grant=%b tready=%b expected 0/00/00",
                 n, o2_tvalid, o2_grant, i2_tready);
      end
    end
    checks++;
    if (o2_tdata !== 32'h0 || o2_tkeep !== 4'h0 || o2_tlast !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_payload: got data=%h keep=%h last=%b expected 0", o2_tdata, o2_tkeep, o2_tlast);
    end
    checks++;
    if (o4_tvalid !== 1'b0 || o4_grant !== 4'h0 || i4_tready !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_ni4: got tvalid=%b grant=%b tready=%b expected 0/0000/0000",
               o4_tvalid, o4_grant, i4_tready);
    end
    rst = 1'b0;
    cycle2();
    checks++;
    if (o2_grant !== 2'b01) begin
      errors++;
      $display("[TB] FAIL reset_first_grant: got %b expected 01", o2_grant);
    end
    i4_tvalid = '0;
  endtask

  task automatic test_round_robin();
    int budget;
    logic [31:0] exp_d;
    do_reset();
    set_src(0, 8'hA0, 3, 3);
    set_src(1, 8'hB0, 3, 3);
    drive2();
    budget = 0;
    while (q_data.size() < 9 && budget < 60) begin
      cycle2();
      budget++;
    end
    checks++;
    if (q_data.size() < 9) begin
      errors++;
      $display("[TB] FAIL rr_timeout: got %0d beats expected 9", q_data.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        exp_d = {24'h0, ((i / 3) % 2 == 0) ? 8'hA0 : 8'hB0} + 32'(i % 3);
        checks++;
        if (q_data[i] !== exp_d || q_last[i] !== (i % 3 == 2) ||
            q_keep[i] !== ((i % 3 == 2) ? 4'h1 : 4'hF)) begin
          errors++;
          $display("[TB] FAIL rr_beat %0d: got data=%h last=%b keep=%h expected data=%h last=%b",
                   i, q_data[i], q_last[i], q_keep[i], exp_d, (i % 3 == 2));
        end
        if (i > 0) begin
          checks++;
          if (q_cyc[i] - q_cyc[i-1] != ((i % 3 == 0) ? 2 : 1)) begin
            errors++;
            $display("[TB] FAIL rr_spacing %0d: got gap %0d expected %0d",
                     i, q_cyc[i] - q_cyc[i-1], (i % 3 == 0) ? 2 : 1);
          end
        end
      end
    end
  endtask

  task automatic test_no_preempt();
    int budget;
    logic [7:0] exp_b[5];
    exp_b = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0};
    do_reset();
    set_src(1, 8'hC0, 4, 1);
    drive2();
    cycle2();
    cycle2();
    src_hold[1] = 1'b1;
    set_src(0, 8'hD0, 1, 1);
    drive2();
    #1;
    for (int n = 0; n < 4; n++) begin
      cycle2();
      checks++;
      if (o2_grant !== 2'b10 || i2_tready[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL preempt_hold cycle %0d: got grant=%b tready0=%b expected 10/0",
                 n, o2_grant, i2_tready[0]);
      end
    end
    src_hold[1] = 1'b0;
    drive2();
    budget = 0;
    while (q_data.size() < 5 && budget < 40) begin
      cycle2();
      budget++;
    end
    checks++;
    if (q_data.size() != 5) begin
      errors++;
      $display("[TB] FAIL preempt_count: got %0d beats expected 5", q_data.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (q_data[i] !== {24'h0, exp_b[i]}) begin
          errors++;
          $display("[TB] FAIL preempt_order %0d: got %h expected %h", i, q_data[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int p[9];
    int stalls;
    p = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
    stalls = 0;
    do_reset();
    set_src(0, 8'hE0, 4, 1);
    drive2();
    for (int t = 0; t < 12; t++) begin
      o2_tready = (t < 9) ? p[t][0] : 1'b1;
      cycle2();
      if (last_stall) begin
        stalls++;
        checks++;
        if (o2_tvalid !== 1'b1 || o2_tdata !== last_od) begin
          errors++;
          $display("[TB] FAIL bp_hold t=%0d: got valid=%b data=%h expected 1/%h", t, o2_tvalid, o2_tdata, last_od);
        end
      end
    end
    checks++;
    if (stalls != 2) begin
      errors++;
      $display("[TB] FAIL bp_stalls: got %0d expected 2", stalls);
    end
    checks++;
    if (q_data.size() != 4) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d beats expected 4", q_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_data[i] !== 32'hE0 + 32'(i) || q_last[i] !== (i == 3)) begin
          errors++;
          $display("[TB] FAIL bp_beat %0d: got data=%h last=%b expected %h/%b",
                   i, q_data[i], q_last[i], 32'hE0 + 32'(i), (i == 3));
        end
      end
    end
  endtask

  task automatic test_rr_four();
    do_reset();
    i4_tkeep  = '1;
    i4_tlast  = 4'hF;
    for (int k = 0; k < 4; k++) i4_tdata[k*32 +: 32] = 32'h40 + 32'(k);
    i4_tvalid = 4'b0010;
    tick4();
    checks++;
    if (o4_grant !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL ni4_setup_grant: got %b expected 0010", o4_grant);
    end
    tick4();
    i4_tvalid = 4'b1010;
    #1;
    checks++;
    if (o4_tvalid !== 1'b1 || o4_tdata !== 32'h41 || o4_grant !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL ni4_setup_beat: got valid=%b data=%h grant=%b expected 1/41/0000",
               o4_tvalid, o4_tdata, o4_grant);
    end
    tick4();
    checks++;
    if (o4_grant !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL ni4_grant_ptr2: got %b expected 1000", o4_grant);
    end
    tick4();
    i4_tvalid = 4'b0010;
    #1;
    checks++;
    if (o4_tdata !== 32'h43 || o4_grant !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL ni4_beat3: got data=%h grant=%b expected 43/0000", o4_tdata, o4_grant);
    end
    tick4();
    checks++;
    if (o4_grant !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL ni4_grant_wrap: got %b expected 0010", o4_grant);
    end
    tick4();
    i4_tvalid = 4'b0000;
    #1;
    checks++;
    if (o4_tdata !== 32'h41 || o4_tvalid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ni4_beat1: got data=%h valid=%b expected 41/1", o4_tdata, o4_tvalid);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    set_src(1, 8'hF0, 5, 1);
    drive2();
    cycle2();
    cycle2();
    cycle2();
    checks++;
    if (o2_tvalid !== 1'b1 || o2_tdata !== 32'hF1) begin
      errors++;
      $display("[TB] FAIL midrst_pre: got valid=%b data=%h expected 1/f1", o2_tvalid, o2_tdata);
    end
    rst = 1'b1;
    set_src(0, 8'h90, 1, 1);
    src_beat[1] = 0;
    drive2();
    cycle2();
    checks++;
    if (o2_tvalid !== 1'b0 || o2_grant !== 2'b00) begin
      errors++;
      $display("[TB] FAIL midrst_clear: got valid=%b grant=%b expected 0/00", o2_tvalid, o2_grant);
    end
    rst = 1'b0;
    cycle2();
    checks++;
    if (o2_grant !== 2'b01) begin
      errors++;
      $display("[TB] FAIL midrst_regrant: got %b expected 01", o2_grant);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cyc = 0;
    test_reset();
    test_round_robin();
    test_no_preempt();
    test_backpressure();
    test_rr_four();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
